// File: rtl/joy_pkg.sv
// Shared definitions for the serial joystick scanner: FSM states, default
// parameter values and the fixed internal counter widths.
package joy_pkg;

    localparam int unsigned DefClkDiv   = 32;
    localparam int unsigned DefNbits    = 24;
    localparam int unsigned DefGapTicks = 64;

    // Widths sized for the largest legal CLK_DIV, NBITS and GAP_TICKS.
    localparam int unsigned CntW = 10;
    localparam int unsigned IdxW = 5;
    localparam int unsigned GapW = 12;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSample,
        StClkHi,
        StDone
    } joy_state_e;

endpackage

// File: rtl/joy_serial_scanner_if.sv
// Signal bundle between a host and the joystick scanner. The slave modport is
// the scanner side; the master modport is the host / chain side.
interface joy_serial_scanner_if;

    logic        ENABLE;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] JOYSTICK1;
    logic [15:0] JOYSTICK2;
    logic        FRAME_DONE;
    logic        BUSY;

    modport master (
        output ENABLE, JOY_DATA,
        input  JOY_CLK, JOY_LOAD, JOYSTICK1, JOYSTICK2, FRAME_DONE, BUSY
    );

    modport slave (
        input  ENABLE, JOY_DATA,
        output JOY_CLK, JOY_LOAD, JOYSTICK1, JOYSTICK2, FRAME_DONE, BUSY
    );

endinterface

// File: rtl/joy_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks.
module joy_tick_gen
    import joy_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic tick_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count 0..CLK_DIV-1 and wrap.
    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/joy_serial_scanner.sv
// Scans an external parallel-in/serial-out button chain: load strobe, then
// NBITS sample/clock-high tick pairs, then publishes both players' buttons.
module joy_serial_scanner
    import joy_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DefClkDiv,
    parameter int unsigned NBITS     = DefNbits,
    parameter int unsigned GAP_TICKS = DefGapTicks
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    joy_serial_scanner_if.slave  joy_io
);

    localparam int unsigned     Half    = NBITS / 2;
    localparam logic [GapW-1:0] GapMax  = GapW'(GAP_TICKS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBITS - 1);

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [1:0]       data_sync_q;
    logic             tick;
    joy_state_e       state_q, state_d;
    logic [GapW-1:0]  gap_q, gap_d, gap_inc;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [15:0]      joy1_q, joy1_d, joy2_q, joy2_d;
    logic             frame_done_q, joy_clk_q, joy_load_q;

    // Reset asserts immediately, releases two clocks after RESET_N rises.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous chain data.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], joy_io.JOY_DATA};
        end
    end

    joy_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .CLK     (CLK),
        .RESET_N (rst_n),
        .tick_o  (tick)
    );

    // Next-state, gap, index, shift capture and output latch logic.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        gap_inc = (gap_q == GapMax) ? gap_q : gap_q + GapW'(1);
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    gap_d = gap_inc;
                    // The tick that completes the gap is the one that starts the frame.
                    if (gap_inc == GapMax && joy_io.ENABLE) begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                idx_d = '0;
                if (tick) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (tick) begin
                    for (int i = 0; i < NBITS; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            shift_d[i] = data_sync_q[1];
                        end
                    end
                    state_d = StClkHi;
                end
            end
            StClkHi: begin
                if (tick) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StSample;
                    end
                end
            end
            StDone: begin
                joy1_d           = '0;
                joy2_d           = '0;
                joy1_d[Half-1:0] = ~shift_q[Half-1:0];
                joy2_d[Half-1:0] = ~shift_q[NBITS-1:Half];
                gap_d            = '0;
                state_d          = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; chain strobes are decoded from the next state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            joy1_q       <= '0;
            joy2_q       <= '0;
            frame_done_q <= 1'b0;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            joy1_q       <= joy1_d;
            joy2_q       <= joy2_d;
            frame_done_q <= (state_q == StDone);
            joy_clk_q    <= (state_d == StClkHi);
            joy_load_q   <= (state_d != StLoad);
        end
    end

    assign joy_io.JOY_CLK    = joy_clk_q;
    assign joy_io.JOY_LOAD   = joy_load_q;
    assign joy_io.JOYSTICK1  = joy1_q;
    assign joy_io.JOYSTICK2  = joy2_q;
    assign joy_io.FRAME_DONE = frame_done_q;
    assign joy_io.BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Directed bench: a 24-bit scanner and a 2-bit scanner, each driven by a
// behavioural shift-register chain, with protocol monitors on both.
module tb_joy_serial_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    joy_serial_scanner_if ifa ();
    joy_serial_scanner_if ifb ();

    joy_serial_scanner #(
        .CLK_DIV   (4),
        .NBITS     (24),
        .GAP_TICKS (2)
    ) u_dut_a (
        .CLK     (clk),
        .RESET_N (rst_n),
        .joy_io  (ifa)
    );

    joy_serial_scanner #(
        .CLK_DIV   (4),
        .NBITS     (2),
        .GAP_TICKS (2)
    ) u_dut_b (
        .CLK     (clk),
        .RESET_N (rst_n),
        .joy_io  (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Chain data is active-low: a pressed button reads as 0.
    function automatic logic [31:0] mk_a(input logic [11:0] p1, input logic [11:0] p2);
        return ~{8'h00, p2, p1};
    endfunction

    // Behavioural chains: parallel load while LOAD is low, shift on JOY_CLK rise.
    logic [31:0] pat_a = '1;
    logic [31:0] sra = '1;
    logic [1:0]  pat_b = 2'b11;
    logic [1:0]  srb = 2'b11;

    always @(posedge ifa.JOY_CLK or negedge ifa.JOY_LOAD) begin
        if (!ifa.JOY_LOAD) sra = pat_a;
        else sra = {1'b1, sra[31:1]};
    end
    always @(posedge ifb.JOY_CLK or negedge ifb.JOY_LOAD) begin
        if (!ifb.JOY_LOAD) srb = pat_b;
        else srb = {1'b1, srb[1]};
    end
    assign ifa.JOY_DATA = sra[0];
    assign ifb.JOY_DATA = srb[0];

    // Protocol monitors.
    int   lw_a = 0, edg_a = 0, bad_a = 0, lw_b = 0, edg_b = 0, bad_b = 0;
    bit   seen_a = 0, seen_b = 0;
    logic pclk_a = 0, pload_a = 1, pclk_b = 0, pload_b = 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            lw_a = 0; edg_a = 0; seen_a = 0;
        end else begin
            if (ifa.JOY_CLK && !ifa.JOY_LOAD) bad_a++;
            if (ifa.JOY_CLK && !pclk_a) edg_a++;
            if (!ifa.JOY_LOAD && pload_a) begin
                if (seen_a) chk("a_clk_edges", edg_a, 24);
                seen_a = 1; edg_a = 0;
            end
            if (!ifa.JOY_LOAD) lw_a++;
            else if (lw_a != 0) begin chk("a_load_width", lw_a, 4); lw_a = 0; end
        end
        pclk_a = ifa.JOY_CLK; pload_a = ifa.JOY_LOAD;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            lw_b = 0; edg_b = 0; seen_b = 0;
        end else begin
            if (ifb.JOY_CLK && !ifb.JOY_LOAD) bad_b++;
            if (ifb.JOY_CLK && !pclk_b) edg_b++;
            if (!ifb.JOY_LOAD && pload_b) begin
                if (seen_b) chk("b_clk_edges", edg_b, 2);
                seen_b = 1; edg_b = 0;
            end
            if (!ifb.JOY_LOAD) lw_b++;
            else if (lw_b != 0) begin chk("b_load_width", lw_b, 4); lw_b = 0; end
        end
        pclk_b = ifb.JOY_CLK; pload_b = ifb.JOY_LOAD;
    end

    task automatic wait_done(input bit use_b, input int budget, output int cyc);
        logic d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            d = use_b ? ifb.FRAME_DONE : ifa.FRAME_DONE;
        end while (!d && cyc < budget);
        chk(use_b ? "b_done_seen" : "a_done_seen", 32'(d), 1);
    endtask

    task automatic wait_a_rises(input int n);
        int   k = 0;
        int   t = 0;
        logic p = ifa.JOY_CLK;
        while (k < n && t < 3000) begin
            @(negedge clk);
            t++;
            if (ifa.JOY_CLK && !p) k++;
            p = ifa.JOY_CLK;
        end
        chk("a_rise_wait", k, n);
    endtask

    initial begin
        int cyc;
        int loads;
        int dones;
        ifa.ENABLE = 1'b1;
        ifb.ENABLE = 1'b1;
        pat_a = mk_a(12'h011, 12'h800);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load", 32'(ifa.JOY_LOAD), 1);
        chk("rst_clk", 32'(ifa.JOY_CLK), 0);
        chk("rst_j1", 32'(ifa.JOYSTICK1), 0);
        chk("rst_j2", 32'(ifa.JOYSTICK2), 0);
        chk("rst_done", 32'(ifa.FRAME_DONE), 0);
        chk("rst_busy", 32'(ifa.BUSY), 0);
        @(negedge clk) rst_n = 1'b1;

        // Basic frame and frame period.
        wait_done(0, 400, cyc);
        chk("a_f1_j1", 32'(ifa.JOYSTICK1), 32'h0011);
        chk("a_f1_j2", 32'(ifa.JOYSTICK2), 32'h0800);
        wait_done(0, 400, cyc);
        chk("a_period", cyc, 204);
        chk("a_f2_j1", 32'(ifa.JOYSTICK1), 32'h0011);

        // All released.
        pat_a = mk_a(12'h000, 12'h000);
        wait_done(0, 400, cyc);
        chk("a_rel_j1", 32'(ifa.JOYSTICK1), 0);
        chk("a_rel_j2", 32'(ifa.JOYSTICK2), 0);

        // Dense pattern.
        pat_a = mk_a(12'hABC, 12'h123);
        wait_done(0, 400, cyc);
        chk("a_abc_j1", 32'(ifa.JOYSTICK1), 32'h0ABC);
        chk("a_abc_j2", 32'(ifa.JOYSTICK2), 32'h0123);

        // ENABLE dropped at bit 10: frame still completes, then idle.
        pat_a = mk_a(12'h555, 12'hAAA);
        wait_a_rises(10);
        ifa.ENABLE = 1'b0;
        wait_done(0, 400, cyc);
        chk("a_dis_j1", 32'(ifa.JOYSTICK1), 32'h0555);
        chk("a_dis_j2", 32'(ifa.JOYSTICK2), 32'h0AAA);
        loads = 0;
        dones = 0;
        repeat (800) begin
            @(negedge clk);
            if (!ifa.JOY_LOAD) loads++;
            if (ifa.FRAME_DONE) dones++;
        end
        chk("a_dis_loads", loads, 0);
        chk("a_dis_dones", dones, 0);
        chk("a_dis_busy", 32'(ifa.BUSY), 0);

        // ENABLE rising with the gap saturated starts LOAD on the next tick.
        @(negedge clk) ifa.ENABLE = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ifa.JOY_LOAD && cyc < 20);
        chk("a_en_rise_lat", 32'(cyc >= 1 && cyc <= 4), 1);

        // Asynchronous reset at bit 15 with JOY_CLK high.
        wait_a_rises(15);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_load", 32'(ifa.JOY_LOAD), 1);
        chk("mid_rst_clk", 32'(ifa.JOY_CLK), 0);
        chk("mid_rst_j1", 32'(ifa.JOYSTICK1), 0);
        chk("mid_rst_j2", 32'(ifa.JOYSTICK2), 0);
        chk("mid_rst_busy", 32'(ifa.BUSY), 0);
        repeat (3) @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_done(0, 400, cyc);
        chk("a_post_rst_lat", 32'(cyc >= 200 && cyc <= 212), 1);
        chk("a_post_rst_j1", 32'(ifa.JOYSTICK1), 32'h0555);
        chk("a_post_rst_j2", 32'(ifa.JOYSTICK2), 32'h0AAA);

        // NBITS=2 boundary.
        wait_done(1, 200, cyc);
        pat_b = 2'b10;
        wait_done(1, 200, cyc);
        chk("b_p1_j1", 32'(ifb.JOYSTICK1), 32'h0001);
        chk("b_p1_j2", 32'(ifb.JOYSTICK2), 32'h0000);
        pat_b = 2'b01;
        wait_done(1, 200, cyc);
        chk("b_period", cyc, 28);
        chk("b_p2_j1", 32'(ifb.JOYSTICK1), 32'h0000);
        chk("b_p2_j2", 32'(ifb.JOYSTICK2), 32'h0001);

        chk("a_clk_with_load", bad_a, 0);
        chk("b_clk_with_load", bad_b, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/joy_serial_scanner.md
JOY_SERIAL_SCANNER -- requirements
Module: joy_serial_scanner

Interface
REQ-001 Parameter CLK_DIV, default 32, meaning CLK cycles per tick; legal range 4..1023.
REQ-002 Parameter NBITS, default 24, meaning bits per frame; even, 2..32, NBITS/2 bits per player.
REQ-003 Parameter GAP_TICKS, default 64, meaning idle ticks between frames; legal range 1..4095.
REQ-004 CLK  input  1  system clock, 40-50 MHz.
REQ-005 RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 ENABLE  input  1  high = start new frames; low = finish current frame, then hold idle.
REQ-007 JOY_DATA  input  1  serial data from external shift-register chain, active-low buttons, asynchronous.
REQ-008 JOY_CLK  output  1  shift clock to chain.
REQ-009 JOY_LOAD  output  1  parallel-load strobe to chain, active-low.
REQ-010 JOYSTICK1  output  16  player-1 buttons, active-high.
REQ-011 JOYSTICK2  output  16  player-2 buttons, active-high.
REQ-012 FRAME_DONE  output  1  one-CLK pulse when JOYSTICK1/2 update.
REQ-013 BUSY  output  1  high in any state other than IDLE.

Function
REQ-014 Prescaler counts 0..CLK_DIV-1 and wraps; tick is asserted for the one CLK where count = CLK_DIV-1; counter free-runs regardless of state.
REQ-015 JOY_DATA passes through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 States: IDLE, LOAD, SAMPLE, CLK_HI, DONE; all transitions except DONE->IDLE occur only on tick.
REQ-017 IDLE: JOY_LOAD=1, JOY_CLK=0; gap counter increments per tick, saturating at GAP_TICKS; at a tick with gap = GAP_TICKS and ENABLE=1 -> LOAD.
REQ-018 LOAD: JOY_LOAD=0, JOY_CLK=0 for exactly one tick period; bit index cleared to 0; -> SAMPLE.
REQ-019 SAMPLE: JOY_LOAD=1, JOY_CLK=0; on tick capture synchronized JOY_DATA into shift[index]; -> CLK_HI.
REQ-020 CLK_HI: JOY_CLK=1; on tick, if index = NBITS-1 -> DONE, else index+1 -> SAMPLE.
REQ-021 DONE lasts one CLK: JOYSTICK1[NBITS/2-1:0] <= ~shift[NBITS/2-1:0], JOYSTICK2[NBITS/2-1:0] <= ~shift[NBITS-1:NBITS/2], upper output bits 0; FRAME_DONE=1; gap counter cleared; -> IDLE.
REQ-022 Frame length: 1 + 2*NBITS ticks from LOAD entry to DONE, plus at least GAP_TICKS idle ticks; first bit sampled is shift[0].
REQ-023 JOYSTICK1/2 change only in DONE; never show a partially shifted frame.
REQ-024 ENABLE falling mid-frame has no effect until DONE; the frame completes and outputs update.
REQ-025 ENABLE rising while gap is saturated starts LOAD at the next tick.
REQ-026 JOY_CLK and JOY_LOAD are registered outputs, glitch-free; JOY_CLK=1 and JOY_LOAD=0 never occur together.

Reset
REQ-027 RESET_N low asynchronously forces: state IDLE, prescaler 0, gap 0, index 0, shift 0, JOYSTICK1/2 = 0, FRAME_DONE 0, BUSY 0, JOY_LOAD 1, JOY_CLK 0.
REQ-028 Reset mid-frame discards the partial frame; after release, the first LOAD occurs no earlier than GAP_TICKS ticks later.
REQ-029 RESET_N release is synchronized inside the block (async assert, sync deassert).

Structure
REQ-030 Shared package joy_pkg holds the state enum and the default values of CLK_DIV, NBITS, GAP_TICKS.
REQ-031 The prescaler is the one sub-module, joy_tick_gen (CLK, RESET_N, tick output, CLK_DIV parameter).
REQ-032 Single clock domain; no latches; no combinational path from JOY_DATA to any output.

Verification
REQ-033 CLK_DIV=4, NBITS=24, GAP_TICKS=2, ENABLE=1, chain model drives P1 bits 0,4 pressed and P2 bit 11 pressed -> JOYSTICK1=16'h0011, JOYSTICK2=16'h0800, FRAME_DONE pulse per frame, frame period (1+48+2)*4 CLK.
REQ-034 All buttons released (JOY_DATA=1) -> JOYSTICK1=JOYSTICK2=16'h0000 after the first DONE.
REQ-035 ENABLE dropped at bit 10 -> frame completes, outputs update once, BUSY low afterward, no further JOY_LOAD pulses.
REQ-036 RESET_N low at bit 15 -> JOY_LOAD=1, JOY_CLK=0, outputs 0 immediately (no CLK edge needed); no FRAME_DONE until a full new frame completes.
REQ-037 Protocol checker across all runs: JOY_LOAD low exactly one tick per frame, exactly NBITS JOY_CLK rising edges between consecutive JOY_LOAD pulses, never JOY_CLK=1 with JOY_LOAD=0.
REQ-038 NBITS=2, CLK_DIV=4 boundary -> JOYSTICK1[0] and JOYSTICK2[0] track the model, bits 15:1 remain 0.
